// File: rtl/i2c_color_receiver_pkg.sv
// Shared types and constants for the color-sensor I2C receiver.
// Byte layout: channel k occupies bytes 2k and 2k+1 of the frame.
package color_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  localparam int NUM_CHANNELS = 5;
  localparam int NUM_BYTES    = 10;

  localparam int CH_CLEAR    = 0;
  localparam int CH_RED      = 1;
  localparam int CH_GREEN    = 2;
  localparam int CH_BLUE     = 3;
  localparam int CH_INFRARED = 4;

  // hi_first=1: the first byte on the wire is [15:8]
  function automatic logic [15:0] pack_word(
    input logic       hi_first,
    input logic [7:0] first,
    input logic [7:0] second
  );
    return hi_first ? {first, second}
                    : {second, first};
  endfunction

endpackage

// File: rtl/i2c_color_receiver_if.sv
// I2C pad bundle between the bus side and the target receiver.
// SDA is open-drain: the target only ever pulls low via sda_oe.
interface i2c_color_receiver_if;

  logic i2c_scl;
  logic i2c_sda_in;
  logic i2c_sda_oe;

  modport master (
    output i2c_scl,
    output i2c_sda_in,
    input  i2c_sda_oe
  );

  modport slave (
    input  i2c_scl,
    input  i2c_sda_in,
    output i2c_sda_oe
  );

endinterface

// File: rtl/i2c_color_receiver_line_sync.sv
// SCL/SDA synchronizers plus edge and START/STOP detection.
// Strobes are one clk wide, three clks after the pin transition.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_lvl
);

  logic [1:0] scl_s;
  logic [1:0] sda_s;
  logic       scl_q;
  logic       sda_q;

  // two-flop sync then one delay stage for edge detection; idle bus is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], scl};
      sda_s <= {sda_s[0], sda};
      scl_q <= scl_s[1];
      sda_q <= sda_s[1];
    end
  end

  assign scl_rise  = scl_s[1] & ~scl_q;
  assign scl_fall  = ~scl_s[1] & scl_q;
  assign start_det = scl_s[1] & scl_q
                   & ~sda_s[1] & sda_q;
  assign stop_det  = scl_s[1] & scl_q
                   & sda_s[1] & ~sda_q;
  assign sda_lvl   = sda_s[1];

endmodule

// File: rtl/i2c_color_receiver.sv
// I2C write-only target for the color sensor: 1 address + 10 data bytes.
// Reassembles five 16-bit channels and commits them as one frame.
module i2c_color_receiver
  import color_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h29
) (
  input  logic                  clk,
  input  logic                  rst_n,
  i2c_color_receiver_if.slave   bus,
  input  logic                  endian,
  output logic [15:0]           clear_data,
  output logic [15:0]           red_data,
  output logic [15:0]           green_data,
  output logic [15:0]           blue_data,
  output logic [15:0]           infrared_data,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  frame_error
);

  localparam logic [3:0] LAST_IDX =
    4'(NUM_BYTES - 1);
  localparam logic [3:0] SAT_IDX =
    4'(NUM_BYTES);

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       sda_lvl;

  state_t     state;
  logic [7:0] shreg;
  logic [3:0] bit_cnt;
  logic [3:0] byte_idx;
  logic [7:0] shadow [NUM_BYTES];
  logic       endian_q;
  logic       ack_on;
  logic       got_all;
  logic       sda_oe_q;
  logic       byte_done;
  logic       abort;
  logic [7:0] frame_b [NUM_BYTES];

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (bus.i2c_scl),
    .sda       (bus.i2c_sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_lvl   (sda_lvl)
  );

  assign bus.i2c_sda_oe = sda_oe_q;
  assign byte_done      = (bit_cnt == 4'd8);
  assign abort          = busy & ~got_all;

  // last byte is still in the shift register on the commit cycle
  always_comb begin
    for (int i = 0; i < NUM_BYTES; i++)
      frame_b[i] = shadow[i];
    frame_b[NUM_BYTES-1] = shreg;
  end

  // receive FSM, shadow bytes and committed channel registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      byte_idx      <= '0;
      endian_q      <= 1'b0;
      ack_on        <= 1'b0;
      got_all       <= 1'b0;
      sda_oe_q      <= 1'b0;
      busy          <= 1'b0;
      data_valid    <= 1'b0;
      frame_error   <= 1'b0;
      clear_data    <= '0;
      red_data      <= '0;
      green_data    <= '0;
      blue_data     <= '0;
      infrared_data <= '0;
      for (int i = 0; i < NUM_BYTES; i++)
        shadow[i] <= '0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (start_det) begin
        frame_error <= abort;
        busy        <= 1'b0;
        got_all     <= 1'b0;
        sda_oe_q    <= 1'b0;
        ack_on      <= 1'b0;
        bit_cnt     <= '0;
        endian_q    <= endian;
        state       <= ADDR;
      end else if (stop_det) begin
        frame_error <= abort;
        busy        <= 1'b0;
        sda_oe_q    <= 1'b0;
        ack_on      <= 1'b0;
        state       <= IDLE;
      end else begin
        unique case (state)
          IDLE: ;
          ADDR: begin
            if (byte_done) begin
              bit_cnt <= '0;
              if (shreg == {DEV_ADDR, 1'b0}) begin
                busy     <= 1'b1;
                byte_idx <= '0;
                state    <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end else if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_lvl};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              ack_on   <= ~ack_on;
              sda_oe_q <= ~ack_on;
              if (ack_on)
                state <= DATA;
            end
          end
          DATA: begin
            if (byte_done) begin
              bit_cnt <= '0;
              if (byte_idx <= LAST_IDX) begin
                shadow[byte_idx] <= shreg;
                state            <= DATA_ACK;
                if (byte_idx == LAST_IDX) begin
                  got_all    <= 1'b1;
                  data_valid <= 1'b1;
                  clear_data <= pack_word(endian_q,
                    frame_b[2*CH_CLEAR],
                    frame_b[2*CH_CLEAR+1]);
                  red_data <= pack_word(endian_q,
                    frame_b[2*CH_RED],
                    frame_b[2*CH_RED+1]);
                  green_data <= pack_word(endian_q,
                    frame_b[2*CH_GREEN],
                    frame_b[2*CH_GREEN+1]);
                  blue_data <= pack_word(endian_q,
                    frame_b[2*CH_BLUE],
                    frame_b[2*CH_BLUE+1]);
                  infrared_data <= pack_word(endian_q,
                    frame_b[2*CH_INFRARED],
                    frame_b[2*CH_INFRARED+1]);
                end
              end else begin
                state <= IGNORE;
              end
            end else if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_lvl};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          DATA_ACK: begin
            if (scl_fall) begin
              ack_on   <= ~ack_on;
              sda_oe_q <= ~ack_on;
              if (ack_on) begin
                state <= DATA;
                if (byte_idx != SAT_IDX)
                  byte_idx <= byte_idx + 4'd1;
              end
            end
          end
          IGNORE: sda_oe_q <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_color_receiver.sv
// Directed bench for i2c_color_receiver with an expected-frame queue.
// Bus is modelled as a wired-AND of master SDA and the target pull-down.
module tb_i2c_color_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl_drv;
  logic        sda_drv;
  logic        endian;
  logic [15:0] clear_data;
  logic [15:0] red_data;
  logic [15:0] green_data;
  logic [15:0] blue_data;
  logic [15:0] infrared_data;
  logic        data_valid;
  logic        busy;
  logic        frame_error;

  int checks   = 0;
  int failures = 0;
  int dv_cnt   = 0;
  int fe_cnt   = 0;
  int dv0;
  int fe0;
  logic busy_seen = 1'b0;
  logic dv_prev   = 1'b0;
  logic [79:0] last_exp = '0;
  logic [79:0] sb [$];

  localparam logic [79:0] PAY1 =
    80'h123456789ABCDEF01122;
  localparam logic [79:0] PAY2 =
    80'hA1B2C3D4E5F60718293A;

  i2c_color_receiver_if bus ();

  assign bus.i2c_scl    = scl_drv;
  assign bus.i2c_sda_in = sda_drv & ~bus.i2c_sda_oe;

  i2c_color_receiver #(.DEV_ADDR(7'h29)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .endian        (endian),
    .clear_data    (clear_data),
    .red_data      (red_data),
    .green_data    (green_data),
    .blue_data     (blue_data),
    .infrared_data (infrared_data),
    .data_valid    (data_valid),
    .busy          (busy),
    .frame_error   (frame_error)
  );

  always #5 clk = ~clk;

  wire [79:0] outs = {clear_data, red_data,
    green_data, blue_data, infrared_data};

  task automatic chk(input string tag,
                     input logic [79:0] obs,
                     input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] expect_frame(
    input logic [79:0] p, input logic e);
    logic [79:0] r;
    logic [7:0]  f;
    logic [7:0]  s;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      f = p[79-16*k -: 8];
      s = p[71-16*k -: 8];
      r[79-16*k -: 16] = e ? {f, s} : {s, f};
    end
    return r;
  endfunction

  // scoreboard pop on each commit pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_seen = 1'b1;
      if (frame_error) fe_cnt++;
      if (data_valid) begin
        dv_cnt++;
        chk("dv_width", 80'(dv_prev), 80'd0);
        if (sb.size() == 0)
          chk("dv_unexpected", 80'(sb.size()), 80'd1);
        else
          chk("frame", outs, sb.pop_front());
      end
      dv_prev = data_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; tick(4);
    scl_drv = 1'b1; tick(8);
    sda_drv = 1'b0; tick(8);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(4); sda_drv = 1'b0;
    tick(4); scl_drv = 1'b1;
    tick(8); sda_drv = 1'b1;
    tick(8);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      tick(4); sda_drv = b[i];
      tick(4); scl_drv = 1'b1;
      tick(8); scl_drv = 1'b0;
    end
  endtask

  task automatic ack_clock(input logic exp_ack,
                           input string tag);
    tick(4); sda_drv = 1'b1;
    tick(4); scl_drv = 1'b1;
    tick(4);
    chk(tag, 80'(bus.i2c_sda_in == 1'b0),
        80'(exp_ack));
    tick(4); scl_drv = 1'b0;
  endtask

  task automatic send_data(input logic [79:0] p,
                           input int n);
    for (int i = 0; i < n; i++) begin
      send_bits(p[79-8*i -: 8]);
      ack_clock(1'b1, "data_ack");
    end
  endtask

  task automatic full_frame(input logic [79:0] p,
                            input logic e);
    endian   = e;
    last_exp = expect_frame(p, e);
    sb.push_back(last_exp);
    i2c_start();
    send_bits(8'h52);
    ack_clock(1'b1, "addr_ack");
    send_data(p, 10);
    i2c_stop();
  endtask

  task automatic mark();
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    busy_seen = 1'b0;
  endtask

  task automatic post(input string tag,
                      input int dv, input int fe);
    tick(4);
    chk({tag, "_dv"}, 80'(dv_cnt - dv0), 80'(dv));
    chk({tag, "_fe"}, 80'(fe_cnt - fe0), 80'(fe));
    chk({tag, "_out"}, outs, last_exp);
    chk({tag, "_busy"}, 80'(busy), 80'd0);
    chk({tag, "_oe"}, 80'(bus.i2c_sda_oe), 80'd0);
  endtask

  task automatic bad_addr(input logic [7:0] a,
                          input string tag);
    mark();
    i2c_start();
    send_bits(a);
    ack_clock(1'b0, {tag, "_nack"});
    i2c_stop();
    post(tag, 0, 0);
    chk({tag, "_busy_seen"}, 80'(busy_seen), 80'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    endian  = 1'b1;
    tick(3);
    chk("rst_data", outs, 80'd0);
    chk("rst_flags",
        80'({data_valid, frame_error,
             busy, bus.i2c_sda_oe}), 80'd0);
    rst_n = 1'b1;
    tick(4);

    mark();
    full_frame(PAY1, 1'b1);
    post("be", 1, 0);
    chk("be_busy_seen", 80'(busy_seen), 80'd1);

    mark();
    full_frame(PAY1, 1'b0);
    post("le", 1, 0);

    bad_addr(8'h54, "mis");
    bad_addr(8'h53, "rd");

    mark();
    endian = 1'b1;
    i2c_start();
    send_bits(8'h52);
    ack_clock(1'b1, "short_addr_ack");
    send_data(PAY2, 4);
    i2c_stop();
    post("short", 0, 1);

    mark();
    full_frame(PAY2, 1'b1);
    post("after_short", 1, 0);

    mark();
    endian   = 1'b0;
    last_exp = expect_frame(PAY2, 1'b0);
    sb.push_back(last_exp);
    i2c_start();
    send_bits(8'h52);
    ack_clock(1'b1, "long_addr_ack");
    send_data(PAY2, 10);
    send_bits(8'hEE);
    ack_clock(1'b0, "byte11_nack");
    i2c_stop();
    post("long", 1, 0);

    i2c_start();
    send_bits(8'h52);
    tick(4); sda_drv = 1'b1;
    tick(4); scl_drv = 1'b1;
    tick(4);
    chk("pre_rst_oe", 80'(bus.i2c_sda_oe), 80'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_oe", 80'(bus.i2c_sda_oe), 80'd0);
    chk("rst_mid_data", outs, 80'd0);
    tick(4); scl_drv = 1'b0;
    tick(2); rst_n = 1'b1;
    i2c_stop();

    mark();
    full_frame(PAY1, 1'b0);
    post("after_rst", 1, 0);

    chk("sb_empty", 80'(sb.size()), 80'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_color_receiver.md
# i2c_color_receiver

I2C target-side receiver for the color-sensor link. It sits at the far end of the sensor's I2C write stream and accepts one address byte plus ten data bytes carrying clear, red, green, blue and infrared samples, in that order, two bytes per channel. It ACKs each accepted byte and reassembles the five 16-bit channel words using the selected byte order. It presents the words as a complete frame with a one-cycle valid pulse. The block runs on the system clock and oversamples SCL/SDA, so it needs no clock from the bus.

## Interface
- `DEV_ADDR`, default 7'h29: 7-bit target address this block answers to.
- `clk`  in  1: system clock. Only clock in the block.
- `rst_n`  in  1: asynchronous reset, active low.
- `i2c_scl`  in  1: bus SCL. Asynchronous to `clk`.
- `i2c_sda_in`  in  1: bus SDA as read back from the pad. Asynchronous to `clk`.
- `i2c_sda_oe`  out  1: 1 = pull SDA low (ACK). 0 = release. Open-drain; never drives high.
- `endian`  in  1: 1 = first byte of each pair is [15:8]. 0 = first byte is [7:0].
- `clear_data`, `red_data`, `green_data`, `blue_data`, `infrared_data`  out  16 each: last complete frame.
- `data_valid`  out  1: one-cycle pulse when all five outputs update together.
- `busy`  out  1: high from an address-matched START until STOP or abort.
- `frame_error`  out  1: one-cycle pulse when a matched frame is aborted before 10 bytes.

## Operation
- **Input conditioning.** SCL and SDA each pass through a 2-flop synchronizer, then a registered edge detector.
- **Bus conditions.** START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- **Bit sampling.** Bits are sampled on SCL rise, MSB first, into an 8-bit shift register with a 0..8 bit counter.
- **States** (`enum` in the package):
  - `IDLE`: START → `ADDR`.
  - `ADDR`: after 8 bits, if {addr, rw} == {DEV_ADDR, 0} → `ADDR_ACK`; otherwise → `IGNORE`.
  - `ADDR_ACK`: `i2c_sda_oe`=1 from the SCL fall after bit 8 until the SCL fall after the 9th clock. `busy` is set. Byte index = 0. Then → `DATA`.
  - `DATA`: after 8 bits, store the byte in shadow byte[index].
    - If index ≤ 9 → `DATA_ACK`.
    - Byte 11 or later: no ACK → `IGNORE`.
  - `DATA_ACK`: ACK is driven exactly as in `ADDR_ACK`. Index increments. Then → `DATA`.
  - `IGNORE`: `i2c_sda_oe`=0. Wait for STOP → `IDLE`, or START → `ADDR`.
- **Endian.** `endian` is latched at each START and held for the frame.
- **Channel assembly.** Channel k uses bytes 2k and 2k+1, where k: 0 = clear, 1 = red, 2 = green, 3 = blue, 4 = infrared.
  - Latched endian = 1: word = {byte[2k], byte[2k+1]}.
  - Latched endian = 0: word = {byte[2k+1], byte[2k]}.
- **Commit.** When byte 10 (index 9) completes, all five outputs load from the shadow registers in the same cycle, and `data_valid` pulses. The commit happens before the 10th ACK, and the 10th byte is still ACKed.
- **STOP.** A STOP in any state → `IDLE`, `busy`=0.
  - If `busy` was 1 and fewer than 10 bytes were received, `frame_error` pulses and the outputs keep their previous frame.
- **Repeated START.** A repeated START while `busy` follows the same abort rule, then → `ADDR`.
- **Edge collision.** START/STOP detection takes priority over a data-bit sample on the same `clk` cycle.
- **Reset.** Reset at any point (including mid-ACK) releases SDA immediately (asynchronous) and discards shadow bytes.

## Timing
- **Reset values.** All data outputs 16'h0000. `data_valid`, `frame_error`, `busy` and `i2c_sda_oe` all 0. State `IDLE`.
- **Pin-to-event latency.** 3 `clk` cycles from a pin transition to the internal edge/event (2 sync + 1 detect).
- **Commit timing.**
  - `data_valid` is asserted on the cycle after the sampled 8th bit of byte 10 is registered.
  - Outputs change on that same edge.
  - Pulse width is exactly 1 cycle.
- **ACK timing.** `i2c_sda_oe` rises 3 cycles after the SCL falling pin edge and falls 3 cycles after the next SCL falling pin edge.
- **Clock ratio.** `clk` ≥ 16× SCL frequency. SCL high and low phases must each be ≥ 4 `clk` cycles.
- **Width.** All arithmetic is unsigned. The byte index is 4 bits and saturates at 10.

## Structure
- **Package `color_i2c_pkg`:**
  - state enum
  - `NUM_CHANNELS`=5, `NUM_BYTES`=10
  - channel index constants `CH_CLEAR`..`CH_INFRARED`
- **Sub-module `i2c_line_sync`:** synchronizers, SCL rise/fall detection, START/STOP detection. Outputs are single-cycle strobes plus the synchronized SDA level.
- **Top level:** FSM, shift register, shadow byte array, output registers.

## Test plan
- **Normal frame, endian=1.** START, 0x52, bytes 12 34 56 78 9A BC DE F0 11 22, STOP → 11 ACKs; `clear`=1234, `red`=5678, `green`=9ABC, `blue`=DEF0, `ir`=1122; one `data_valid`.
- **Same frame, endian=0.** → `clear`=3412, `red`=7856, `green`=BC9A, `blue`=F0DE, `ir`=2211.
- **Address mismatch.** Address byte 0x54 (addr 0x2A) → no ACK, `busy` stays 0, outputs unchanged, no `data_valid`/`frame_error`.
- **Read bit set.** Address byte 0x53 → NACK, `IGNORE`, no output change.
- **Short frame.** STOP after 4 data bytes → `frame_error` pulses once, outputs keep the previous frame. A following full frame commits correctly.
- **Reset mid-ACK.** `rst_n` low while `i2c_sda_oe`=1 → SDA released at once; all outputs 0; next full frame is received normally.
